// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared state encoding and defaults for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam int RESET_VECTOR_DEFAULT = 0;

    function automatic logic busy_state(input state_t s);
        return s inside {S_FETCH, S_ISSUE};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control, instruction memory and issue signals of the fetch sequencer
interface fetch_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             START;
    logic             STALL;
    logic             HALT_REQ;
    logic             BRANCH_VALID;
    logic [WIDTH-1:0] BRANCH_TARGET;
    logic             IMEM_REQ;
    logic [WIDTH-1:0] IMEM_ADDR;
    logic             IMEM_ACK;
    logic [WIDTH-1:0] IMEM_DATA;
    logic             INSTR_VALID;
    logic             INSTR_READY;
    logic [WIDTH-1:0] INSTR_OUT;
    logic [WIDTH-1:0] PC_OUT;
    logic             BUSY;

    modport master (
        input  START, STALL, HALT_REQ, BRANCH_VALID, BRANCH_TARGET,
               IMEM_ACK, IMEM_DATA, INSTR_READY,
        output IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR_OUT, PC_OUT, BUSY
    );

    modport slave (
        output START, STALL, HALT_REQ, BRANCH_VALID, BRANCH_TARGET,
               IMEM_ACK, IMEM_DATA, INSTR_READY,
        input  IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR_OUT, PC_OUT, BUSY
    );
endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// pc_reg: program counter register with load enable and async active-low reset
module pc_reg #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_pc
);
    logic [WIDTH-1:0] r_pc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_pc <= RESET_VECTOR;
        else if (i_load)
            r_pc <= i_value;
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IDLE/FETCH/ISSUE/HALTED instruction fetch FSM with next-PC mux
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RST,
    fetch_sequencer_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_capture;
    logic             w_handshake;
    logic             w_pc_load;

    assign w_capture   = r_state == S_FETCH && !bus.STALL && bus.IMEM_ACK;
    assign w_handshake = r_state == S_ISSUE && !bus.STALL && bus.INSTR_READY;
    assign w_next_pc   = bus.BRANCH_VALID ? bus.BRANCH_TARGET : w_pc + WIDTH'(1);
    // IDLE keeps reloading the vector so the PC is pinned there whatever happened before
    assign w_pc_load   = w_handshake || r_state == S_IDLE;

    pc_reg #(
        .WIDTH       (WIDTH),
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc_reg (
        .CLK    (CLK),
        .RST    (RST),
        .i_load (w_pc_load),
        .i_value(w_handshake ? w_next_pc : RESET_VECTOR),
        .o_pc   (w_pc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture)
                r_instr <= bus.IMEM_DATA;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!bus.STALL)
            unique case (r_state)
                S_IDLE, S_HALTED: w_next = bus.START ? S_FETCH : r_state;
                S_FETCH:          w_next = bus.IMEM_ACK ? S_ISSUE : S_FETCH;
                S_ISSUE:          w_next = !bus.INSTR_READY ? S_ISSUE : bus.HALT_REQ ? S_HALTED : S_FETCH;
                default:          w_next = S_IDLE;
            endcase
    end

    assign bus.IMEM_REQ    = r_state == S_FETCH && !bus.STALL;
    assign bus.IMEM_ADDR   = w_pc;
    assign bus.INSTR_VALID = r_state == S_ISSUE;
    assign bus.INSTR_OUT   = r_instr;
    assign bus.PC_OUT      = w_pc;
    assign bus.BUSY        = busy_state(r_state);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer fetch, branch, stall, halt and reset
module tb_fetch_sequencer;
    localparam int          W  = 16;
    localparam logic [W-1:0] RV = 16'h0000;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.WIDTH(W)) bus ();

    fetch_sequencer #(
        .WIDTH       (W),
        .RESET_VECTOR(RV)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    item_t fetch_q[$];
    item_t issue_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [W-1:0] mem(input logic [W-1:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_q(input string tag, input logic from_fetch, output item_t it);
        it = '0;
        if ((from_fetch ? fetch_q.size() : issue_q.size()) == 0)
            check({tag, "_queue_empty"}, W'(0), W'(1));
        else
            it = from_fetch ? fetch_q.pop_front() : issue_q.pop_front();
    endtask

    task automatic check_halted(input string tag, input logic [W-1:0] pc);
        check({tag, "_busy"}, W'(bus.BUSY), W'(0));
        check({tag, "_req"}, W'(bus.IMEM_REQ), W'(0));
        check({tag, "_valid"}, W'(bus.INSTR_VALID), W'(0));
        check({tag, "_pc"}, bus.PC_OUT, pc);
    endtask

    // Called just after the edge that entered FETCH; returns after the handshake edge.
    task automatic do_instr(input int dly, input int stall_f, input int stall_i, input int rdy_dly,
                            input logic br, input logic [W-1:0] tgt, input logic halt);
        item_t        f;
        item_t        i;
        logic [W-1:0] nxt;
        @(negedge clk);
        pop_q("fetch", 1'b1, f);
        check("fetch_req", W'(bus.IMEM_REQ), W'(1));
        check("fetch_addr", bus.IMEM_ADDR, f.pc);
        check("fetch_busy", W'(bus.BUSY), W'(1));
        bus.HALT_REQ = halt;
        if (stall_f > 0) begin
            bus.STALL     = 1'b1;
            bus.IMEM_ACK  = 1'b1;
            bus.IMEM_DATA = 16'hBAD0;
            for (int k = 0; k < stall_f; k++) begin
                #1;
                check("stallf_req", W'(bus.IMEM_REQ), W'(0));
                check("stallf_valid", W'(bus.INSTR_VALID), W'(0));
                check("stallf_addr", bus.IMEM_ADDR, f.pc);
                @(negedge clk);
            end
            bus.STALL    = 1'b0;
            bus.IMEM_ACK = 1'b0;
            #1;
            check("stallf_resume_req", W'(bus.IMEM_REQ), W'(1));
            check("stallf_resume_addr", bus.IMEM_ADDR, f.pc);
        end
        repeat (dly) begin
            @(negedge clk);
            check("wait_req", W'(bus.IMEM_REQ), W'(1));
            check("wait_valid", W'(bus.INSTR_VALID), W'(0));
        end
        i.pc    = f.pc;
        i.instr = mem(f.pc);
        issue_q.push_back(i);
        bus.IMEM_ACK  = 1'b1;
        bus.IMEM_DATA = mem(bus.IMEM_ADDR);
        @(negedge clk);
        bus.IMEM_ACK  = 1'b0;
        bus.IMEM_DATA = '0;
        pop_q("issue", 1'b0, i);
        check("issue_valid", W'(bus.INSTR_VALID), W'(1));
        check("issue_req", W'(bus.IMEM_REQ), W'(0));
        check("issue_instr", bus.INSTR_OUT, i.instr);
        check("issue_pc", bus.PC_OUT, i.pc);
        if (stall_i > 0) begin
            bus.STALL         = 1'b1;
            bus.INSTR_READY   = 1'b1;
            bus.BRANCH_VALID  = 1'b1;
            bus.BRANCH_TARGET = 16'hDEAD;
            for (int k = 0; k < stall_i; k++) begin
                @(negedge clk);
                check("stalli_valid", W'(bus.INSTR_VALID), W'(1));
                check("stalli_instr", bus.INSTR_OUT, i.instr);
                check("stalli_pc", bus.PC_OUT, i.pc);
            end
            bus.STALL = 1'b0;
        end
        bus.INSTR_READY   = 1'b0;
        bus.BRANCH_VALID  = 1'b1;
        bus.BRANCH_TARGET = 16'hBEEF;
        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge clk);
            check("hold_valid", W'(bus.INSTR_VALID), W'(1));
            check("hold_instr", bus.INSTR_OUT, i.instr);
            check("hold_pc", bus.PC_OUT, i.pc);
        end
        nxt               = br ? tgt : f.pc + 16'd1;
        bus.INSTR_READY   = 1'b1;
        bus.BRANCH_VALID  = br;
        bus.BRANCH_TARGET = tgt;
        fetch_q.push_back('{nxt, '0});
        @(posedge clk);
        #1;
        bus.INSTR_READY  = 1'b0;
        bus.BRANCH_VALID = 1'b0;
        bus.HALT_REQ     = 1'b0;
        if (halt) begin
            @(negedge clk);
            check_halted("halt", nxt);
        end
    endtask

    task automatic pulse_start();
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
    endtask

    initial begin
        item_t f;
        bus.START         = 1'b0;
        bus.STALL         = 1'b0;
        bus.HALT_REQ      = 1'b0;
        bus.BRANCH_VALID  = 1'b0;
        bus.BRANCH_TARGET = '0;
        bus.IMEM_ACK      = 1'b0;
        bus.IMEM_DATA     = '0;
        bus.INSTR_READY   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", W'(bus.BUSY), W'(0));
        check("rst_req", W'(bus.IMEM_REQ), W'(0));
        check("rst_valid", W'(bus.INSTR_VALID), W'(0));
        check("rst_instr", bus.INSTR_OUT, '0);
        check("rst_pc", bus.PC_OUT, RV);
        check("rst_addr", bus.IMEM_ADDR, RV);
        rst_n = 1'b1;
        fetch_q.push_back('{RV, '0});
        pulse_start();
        do_instr(0, 0, 0, 0, 1'b0, '0, 1'b0);
        do_instr(0, 0, 0, 0, 1'b0, '0, 1'b0);
        do_instr(0, 0, 0, 0, 1'b1, 16'h0005, 1'b0);
        do_instr(0, 0, 0, 0, 1'b1, 16'h0040, 1'b0);
        do_instr(1, 0, 0, 0, 1'b1, 16'hFFFF, 1'b0);
        do_instr(0, 0, 0, 0, 1'b0, '0, 1'b0);
        do_instr(0, 3, 3, 2, 1'b0, '0, 1'b0);
        do_instr(0, 0, 0, 0, 1'b1, 16'h0010, 1'b0);
        do_instr(4, 0, 0, 0, 1'b0, '0, 1'b1);
        bus.IMEM_ACK = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_halted("halted_ack", 16'h0011);
        end
        bus.IMEM_ACK = 1'b0;
        pulse_start();
        do_instr(2, 0, 0, 1, 1'b0, '0, 1'b0);
        @(negedge clk);
        pop_q("midrst", 1'b1, f);
        check("midrst_req_before", W'(bus.IMEM_REQ), W'(1));
        check("midrst_addr_before", bus.IMEM_ADDR, f.pc);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req", W'(bus.IMEM_REQ), W'(0));
        check("midrst_valid", W'(bus.INSTR_VALID), W'(0));
        check("midrst_busy", W'(bus.BUSY), W'(0));
        check("midrst_pc", bus.PC_OUT, RV);
        check("midrst_instr", bus.INSTR_OUT, '0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_q.push_back('{RV, '0});
        pulse_start();
        do_instr(0, 0, 0, 0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("final_req", W'(bus.IMEM_REQ), W'(1));
        check("final_addr", bus.IMEM_ADDR, RV + 16'd1);
        check("queues_drained", W'(fetch_q.size() + issue_q.size()), W'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
